// File: rtl/gray_binary_counter.sv
// gray_binary_counter: modulo-MODULUS up/down counter with binary or Gray output encoding
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   mode       0 = binary count/load_value, 1 = Gray count/load_value
//   up         1 = increment, 0 = decrement
//   en         advance one step per cycle
//   load       parallel load of load_value (wins over en)
//   load_value load data, encoded per mode; decoded values >= MODULUS saturate to MODULUS-1
//   count      registered encode(idx, mode)
//   wrap       registered pulse on the cycle count shows the wrapped value
// When MODULUS is not a power of two, the Gray step MODULUS-1 -> 0 changes more than one bit.
module gray_binary_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] idx, idx_next, gray_dec, ld_dec, ld_sat;
    logic             wrap_next;
    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        gray_dec = '0;
        for (int i = 0; i < WIDTH; i++)
            gray_dec[i] = ^(load_value >> i);
    end
    assign ld_dec    = mode ? gray_dec : load_value;
    assign ld_sat    = int'(ld_dec) >= MODULUS ? LAST : ld_dec;
    assign wrap_next = en && !load && (up ? idx == LAST : idx == '0);
    assign idx_next  = load ? ld_sat :
                       !en  ? idx :
                       up   ? (idx == LAST ? '0 : idx + 1'b1) :
                              (idx == '0 ? LAST : idx - 1'b1);
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            idx   <= idx_next;
            count <= mode ? idx_next ^ (idx_next >> 1) : idx_next;
            wrap  <= wrap_next;
        end
    end
endmodule

// File: doc/gray_binary_counter.md
# gray_binary_counter

Parametrised up/down counter with selectable binary or Gray output encoding, the next generation of our 3-bit binary/Gray mode counter. The count advances a single internal binary index. `mode` selects how that index is encoded on `count`, so switching encoding mid-run never loses position. The block adds width and modulus parameters, direction control, count enable, parallel load and a registered wrap pulse. It serves as a sequence source for the lab datapaths and as a Gray pointer generator for clock-domain-safe addressing.

## Interface
- `WIDTH`, 3: counter and output width in bits, ≥ 2.
- `MODULUS`, 2**WIDTH: number of states; index runs 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.

- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `mode`  input  1  0 = binary output encoding, 1 = Gray output encoding.
- `up`  input  1  1 = increment, 0 = decrement.
- `en`  input  1  count enable; advance one step per cycle while high.
- `load`  input  1  parallel load strobe.
- `load_value`  input  WIDTH  value to load, in the encoding currently selected by `mode`.
- `count`  output  WIDTH  registered count, encoded per `mode`.
- `wrap`  output  1  registered one-cycle pulse marking a wrap-around step.

## Operation
- Internal state is the binary index `idx`, WIDTH bits.
  - `count` is registered as encode(idx_next, mode).
  - Binary encoding: the index itself.
  - Gray encoding: idx ^ (idx >> 1).
- Actions are evaluated at each rising `clk`, highest priority first:
  1. `reset`: idx=0, count=0, wrap=0.
  2. `load`: idx = decoded `load_value`, wrap=0.
     - In Gray mode, `load_value` is Gray-to-binary converted by prefix XOR from the MSB.
     - A decoded value ≥ MODULUS saturates to MODULUS-1.
  3. `en` with `up`=1: idx = (idx==MODULUS-1) ? 0 : idx+1. wrap=1 exactly when idx was MODULUS-1.
  4. `en` with `up`=0: idx = (idx==0) ? MODULUS-1 : idx-1. wrap=1 exactly when idx was 0.
  5. Otherwise idx holds and wrap=0.
- `mode` is sampled every cycle regardless of `en`. A mode change re-encodes `count` at the next edge with idx unchanged.
- `load` together with `en` performs the load only; no step occurs that cycle.
- `up` may change on any cycle. The direction takes effect on the next enabled step, with no extra penalty.
- If MODULUS is not a power of two, the Gray wrap step MODULUS-1→0 is not single-bit. This is permitted and must be documented to users.
- Arithmetic is modulo MODULUS only. Intermediate values never exceed WIDTH bits.

## Timing
- All outputs are registered and change only on the rising `clk` edge.
- Reset values: `count`=0 and `wrap`=0, from the first edge with `reset`=1.
- Reset asserted mid-count clears the block at that edge. The first step after `reset` falls yields idx=1 (up) or MODULUS-1 (down), provided `en`=1.
- Latency for `en`, `load`, `up` and `mode`: one cycle. The input is sampled at edge N and the result is visible after edge N.
- `wrap` is high in the same cycle that `count` shows the wrapped value, and for that cycle only. With continuous `en`, it repeats every MODULUS cycles.
- There is no handshake. `en` may be held high indefinitely at one step per cycle.

## Test plan
- WIDTH=3: reset 2 cycles, then `en`=1, `up`=1, `mode`=0 for 9 cycles -> count 1,2,3,4,5,6,7,0,1. wrap is high only on the cycle count=0.
- Same sequence with `mode`=1 -> count 001,011,010,110,111,101,100,000,001. Exactly one bit changes per step; wrap is high on 000.
- Binary up-count to idx=5 (count=101), then `mode`=1 with `en`=0 for 1 cycle -> count=111 (Gray of 5). Then `en`=1 -> 101 (Gray of 6).
- `up`=0 from reset, `mode`=0, `en`=1 -> 7,6,5. wrap is high on 7. Then `load`=1, `load_value`=3 with `en`=1 -> count=3, no step taken, wrap=0.
- MODULUS=6, WIDTH=3, binary up -> 1,2,3,4,5,0, wrap high on 0. `load_value`=7 in binary mode -> count=5. In Gray mode, `load_value`=100 (decodes to 7) -> idx saturates to 5, count=111.
- Counting with `en`=1 at count=6, `reset`=1 for 1 cycle -> count=0, wrap=0. Next cycle with `reset`=0 -> count=1.
